// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory initiator.
//   size_e  - CmdSize encoding (byte/half/word/reserved)
//   state_e - initiator FSM states
//   BYTE_W / LANES - byte-lane geometry of the 32-bit bus
package cpu_mem_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQUEST   = 2'b01,
        WAIT_READ = 2'b10,
        RESPOND   = 2'b11
    } state_e;

    // A command that can never reach the bus: misaligned half/word or reserved size.
    function automatic logic cmd_bad(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            SZ_RSVD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_initiator_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
//   size_i, sgn_i, addr_lo_i - registered command attributes
//   wdata_i  -> be_o, wdata_o : lane enables and replicated store data
//   rdata_i  -> rdata_o       : extracted and extended load data
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  size_e              size_i,
    input  logic               sgn_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        rdata_i,
    output logic [LANES-1:0]   be_o,
    output logic [31:0]        wdata_o,
    output logic [31:0]        rdata_o
);

    logic [31:0] rd_shift;

    // Bring the addressed byte/half down to bit 0.
    assign rd_shift = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o    = '0;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[BYTE_W-1:0]}};
                rdata_o = {{24{sgn_i & rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[2*BYTE_W-1:0]}};
                rdata_o = {{16{sgn_i & rd_shift[15]}}, rd_shift[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = '0;
                wdata_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem_initiator.sv
// cpu_mem_initiator: turns single core load/store commands into one
// memory-controller request, returning a one-cycle response pulse.
//   CoreClock/CoreResetN - clock, synchronous active-low reset
//   Cmd*                 - command handshake (accepted only in IDLE)
//   Rsp*                 - response pulse; data/fault hold between pulses
//   Mem*                 - request/grant plus read-data return
module cpu_mem_initiator
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CoreClock,
    input  logic        CoreResetN,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic [1:0]  CmdSize,
    input  logic        CmdSigned,
    input  logic [31:0] CmdAddress,
    input  logic [31:0] CmdWriteData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspFault,
    output logic        MemRequest,
    input  logic        MemGrant,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [3:0]  MemByteEnable,
    output logic [31:0] MemWriteData,
    input  logic        MemReadValid,
    input  logic [31:0] MemReadData
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               write_q, write_d;
    size_e              size_q, size_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_fault_q, rsp_fault_d;

    logic               cmd_acc;
    logic               timeout_hit;
    logic [LANES-1:0]   lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;

    mem_lane_align u_align (
        .size_i    (size_q),
        .sgn_i     (sgn_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (MemReadData),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    // ready_q is a registered copy of "next state is IDLE", so it is low
    // through reset and rises on the first edge after release.
    assign cmd_acc     = CmdValid && ready_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    write_d = CmdWrite;
                    size_d  = size_e'(CmdSize);
                    sgn_d   = CmdSigned;
                    addr_d  = CmdAddress;
                    wdata_d = CmdWriteData;
                    cnt_d   = '0;
                    if (cmd_bad(size_e'(CmdSize), CmdAddress[1:0])) begin
                        state_d     = RESPOND;
                        rsp_data_d  = '0;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d = REQUEST;
                    end
                end
            end
            REQUEST: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Grant beats a simultaneous timeout.
                if (MemGrant) begin
                    if (write_q) begin
                        state_d     = RESPOND;
                        rsp_data_d  = '0;
                        rsp_fault_d = 1'b0;
                    end else if (MemReadValid) begin
                        // Read data returned in the grant cycle belongs to this load.
                        state_d     = RESPOND;
                        rsp_data_d  = lane_rdata;
                        rsp_fault_d = 1'b0;
                    end else begin
                        state_d = WAIT_READ;
                    end
                end else if (timeout_hit) begin
                    state_d     = RESPOND;
                    rsp_data_d  = '0;
                    rsp_fault_d = 1'b1;
                end
            end
            WAIT_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (MemReadValid) begin
                    state_d     = RESPOND;
                    rsp_data_d  = lane_rdata;
                    rsp_fault_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RESPOND;
                    rsp_data_d  = '0;
                    rsp_fault_d = 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            write_q     <= write_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Bus fields come from registers captured at accept, so they cannot move
    // while the request waits for a grant; outside REQUEST they read as zero.
    assign MemRequest    = (state_q == REQUEST);
    assign MemWrite      = MemRequest & write_q;
    assign MemAddress    = MemRequest ? {addr_q[31:2], 2'b00} : '0;
    assign MemByteEnable = MemRequest ? lane_be : '0;
    assign MemWriteData  = MemRequest ? lane_wdata : '0;

    assign CmdReady = ready_q;
    assign RspValid = (state_q == RESPOND);
    assign RspData  = rsp_data_q;
    assign RspFault = rsp_fault_q;

endmodule
